// File: rtl/fp_pkg.sv
// Shared FP-add normalization constants and the normalized-result record.
package fp_pkg;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SUM_W  = 25;
    localparam int BIAS   = 127;

    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              zero;
    } norm_res_t;
endpackage

// File: rtl/norm_arb_if.sv
// Requester-side and result-side valid/ready bundle for the shared normalizer.
interface norm_arb_if #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
);
    import fp_pkg::*;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [EXP_W*N_REQ-1:0] req_exp;
    logic [SUM_W*N_REQ-1:0] req_frac;
    logic                   out_valid;
    logic                   out_ready;
    logic [TAG_W-1:0]       out_tag;
    logic [EXP_W-1:0]       out_exp;
    logic [FRAC_W-1:0]      out_frac;
    logic                   out_zero;

    modport slave (
        input  req_valid, req_exp, req_frac, out_ready,
        output req_ready, out_valid, out_tag, out_exp, out_frac, out_zero
    );

    modport master (
        output req_valid, req_exp, req_frac, out_ready,
        input  req_ready, out_valid, out_tag, out_exp, out_frac, out_zero
    );
endinterface

// File: rtl/norm_core.sv
// Combinational normalize: leading-one detect, left shift, biased exponent adjust.
// Exponent wraps modulo 256 on purpose, matching the existing add path.
module norm_core
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0] i_exp,
    input  logic [SUM_W-1:0] i_frac,
    output norm_res_t        o_res
);
    logic [4:0]        w_lead;
    logic [4:0]        w_sh;
    logic [FRAC_W-1:0] w_shifted;

    always_comb begin
        w_lead = '0;
        for (int k = 0; k < SUM_W - 1; k++) begin
            if (i_frac[k]) w_lead = 5'(k);
        end
        w_sh      = 5'd23 - w_lead;
        // Bits shifted past position 22 are the hidden one, so a 23-bit shift suffices.
        w_shifted = i_frac[FRAC_W-1:0] << w_sh;

        o_res = '0;
        if (i_frac == '0) begin
            o_res.zero = 1'b1;
        end else if (i_frac[SUM_W-1]) begin
            o_res.exp  = i_exp + 8'(BIAS + 1);
            o_res.frac = i_frac[FRAC_W:1];
        end else begin
            o_res.exp  = i_exp - {3'b000, w_sh} + 8'(BIAS);
            o_res.frac = w_shifted;
        end
    end
endmodule

// File: rtl/norm_arb.sv
// Round-robin arbiter feeding a capture + normalize/result register pair; 2 edges transfer-to-result.
// Full backpressure: req_ready drops when stage 1 cannot advance; 1 result/cycle when out_ready stays high.
module norm_arb
    import fp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    norm_arb_if.slave  bus
);
    logic              w_adv_out;
    logic              w_adv_s1;
    logic              w_gnt_any;
    logic [TAG_W-1:0]  w_gnt_idx;
    logic [EXP_W-1:0]  w_gnt_exp;
    logic [SUM_W-1:0]  w_gnt_frac;
    logic [N_REQ-1:0]  w_gnt;
    int                w_idx;
    norm_res_t         w_norm;

    logic [TAG_W-1:0]  r_ptr;
    logic              r_s1_vld;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [SUM_W-1:0]  r_s1_frac;
    logic [TAG_W-1:0]  r_s1_tag;
    logic              r_out_vld;
    logic [TAG_W-1:0]  r_out_tag;
    norm_res_t         r_out_res;

    always_comb begin
        w_adv_out  = !r_out_vld || bus.out_ready;
        w_adv_s1   = !r_s1_vld || w_adv_out;
        w_gnt_any  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_exp  = '0;
        w_gnt_frac = '0;
        w_idx      = 0;
        // Scan starts just past the last winner so every requester gets a turn.
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % N_REQ;
            if (!w_gnt_any && bus.req_valid[w_idx]) begin
                w_gnt_any  = 1'b1;
                w_gnt_idx  = TAG_W'(w_idx);
                w_gnt_exp  = bus.req_exp[w_idx*EXP_W +: EXP_W];
                w_gnt_frac = bus.req_frac[w_idx*SUM_W +: SUM_W];
            end
        end
        if (!w_adv_s1 || rst) w_gnt_any = 1'b0;
        w_gnt = w_gnt_any ? (N_REQ'(1) << w_gnt_idx) : '0;
    end

    norm_core u_norm_core (
        .i_exp  (r_s1_exp),
        .i_frac (r_s1_frac),
        .o_res  (w_norm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= TAG_W'(N_REQ - 1);
            r_s1_vld  <= 1'b0;
            r_s1_exp  <= '0;
            r_s1_frac <= '0;
            r_s1_tag  <= '0;
            r_out_vld <= 1'b0;
            r_out_tag <= '0;
            r_out_res <= '0;
        end else begin
            if (w_gnt_any) begin
                r_ptr     <= w_gnt_idx;
                r_s1_exp  <= w_gnt_exp;
                r_s1_frac <= w_gnt_frac;
                r_s1_tag  <= w_gnt_idx;
            end
            r_s1_vld <= w_gnt_any || (r_s1_vld && !w_adv_out);
            if (w_adv_out && r_s1_vld) begin
                r_out_tag <= r_s1_tag;
                r_out_res <= w_norm;
            end
            r_out_vld <= r_s1_vld || (r_out_vld && !bus.out_ready);
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.out_valid = r_out_vld;
    assign bus.out_tag   = r_out_tag;
    assign bus.out_exp   = r_out_res.exp;
    assign bus.out_frac  = r_out_res.frac;
    assign bus.out_zero  = r_out_res.zero;
endmodule

// File: tb/tb_norm_arb.sv
// Directed bench for norm_arb: reset, normalization vectors, round robin, backpressure, mid-flight reset.
module tb_norm_arb;
    import fp_pkg::*;

    localparam int N_REQ = 4;
    localparam int TAG_W = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    norm_arb_if #(.N_REQ(N_REQ), .TAG_W(TAG_W)) bus ();

    norm_arb #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [7:0] e, input logic [24:0] f);
        bus.req_exp[idx*8 +: 8]   = e;
        bus.req_frac[idx*25 +: 25] = f;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        bus.req_exp   = '0;
        bus.req_frac  = '0;
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'h33, 25'h0800000);
        tick();
        tick();
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_tag !== 2'd0) begin bad++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
        total++; if (bus.out_exp !== 8'h00) begin bad++; $display("FAIL reset_out_exp: got %h want 00", bus.out_exp); end
        total++; if (bus.out_frac !== 23'h0) begin bad++; $display("FAIL reset_out_frac: got %h want 0", bus.out_frac); end
        total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL reset_out_zero: got %b want 0", bus.out_zero); end
        rst = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", bus.req_ready); end
        bus.req_valid = '0;
    endtask

    task automatic test_norm(input int idx, input logic [7:0] e, input logic [24:0] f,
                             input logic [7:0] ee, input logic [22:0] ef, input logic ez);
        logic [3:0] rdy;
        rdy = 4'b0001 << idx;
        tick();
        bus.req_valid      = '0;
        bus.req_valid[idx] = 1'b1;
        set_req(idx, e, f);
        #1;
        total++; if (bus.req_ready !== rdy) begin bad++; $display("FAIL norm_ready req%0d: got %b want %b", idx, bus.req_ready, rdy); end
        tick();
        bus.req_valid = '0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL norm_early_valid req%0d: got %b want 0", idx, bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL norm_valid req%0d: got %b want 1", idx, bus.out_valid); end
        total++; if (bus.out_tag !== TAG_W'(idx)) begin bad++; $display("FAIL norm_tag req%0d: got %0d want %0d", idx, bus.out_tag, idx); end
        total++; if (bus.out_exp !== ee) begin bad++; $display("FAIL norm_exp frac=%h: got %h want %h", f, bus.out_exp, ee); end
        total++; if (bus.out_frac !== ef) begin bad++; $display("FAIL norm_frac frac=%h: got %h want %h", f, bus.out_frac, ef); end
        total++; if (bus.out_zero !== ez) begin bad++; $display("FAIL norm_zero frac=%h: got %b want %b", f, bus.out_zero, ez); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL norm_single_shot req%0d: got %b want 0", idx, bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] rdy;
        logic [1:0] tag;
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'(i), 25'h0800000);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            bus.req_valid = 4'b1111;
            #1;
            rdy = 4'b0001 << (c % 4);
            total++; if (bus.req_ready !== rdy) begin bad++; $display("FAIL rr_grant c=%0d: got %b want %b", c, bus.req_ready, rdy); end
            if (c >= 2) begin
                tag = 2'((c - 2) % 4);
                total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid c=%0d: got %b want 1", c, bus.out_valid); end
                total++; if (bus.out_tag !== tag) begin bad++; $display("FAIL rr_tag c=%0d: got %0d want %0d", c, bus.out_tag, tag); end
                total++; if (bus.out_exp !== 8'h7F + 8'(tag)) begin bad++; $display("FAIL rr_exp c=%0d: got %h want %h", c, bus.out_exp, 8'h7F + 8'(tag)); end
            end else begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rr_fill c=%0d: got %b want 0", c, bus.out_valid); end
            end
        end
        bus.req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] rdy_tab [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                                     4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic       vld_tab [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] tag_tab [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'h10 + 8'(i), 25'h0800000);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            bus.req_valid = (c < 6) ? 4'b0111 : 4'b0000;
            bus.out_ready = (c >= 5);
            #1;
            total++; if (bus.req_ready !== rdy_tab[c]) begin bad++; $display("FAIL bp_ready c=%0d: got %b want %b", c, bus.req_ready, rdy_tab[c]); end
            total++; if (bus.out_valid !== vld_tab[c]) begin bad++; $display("FAIL bp_valid c=%0d: got %b want %b", c, bus.out_valid, vld_tab[c]); end
            if (vld_tab[c]) begin
                total++; if (bus.out_tag !== tag_tab[c]) begin bad++; $display("FAIL bp_tag c=%0d: got %0d want %0d", c, bus.out_tag, tag_tab[c]); end
                total++; if (bus.out_exp !== 8'h8F + 8'(tag_tab[c])) begin bad++; $display("FAIL bp_exp c=%0d: got %h want %h", c, bus.out_exp, 8'h8F + 8'(tag_tab[c])); end
            end
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'h20, 25'h0800000);
        bus.req_valid = 4'b1111;
        tick();
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_full: got %b want 1", bus.out_valid); end
        rst = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_rst_ready: got %b want 0000", bus.req_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.out_tag !== 2'd0) begin bad++; $display("FAIL mid_out_tag: got %0d want 0", bus.out_tag); end
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_no_stale: got %b want 0", bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_after_valid: got %b want 1", bus.out_valid); end
        total++; if (bus.out_tag !== 2'd0) begin bad++; $display("FAIL mid_after_tag: got %0d want 0", bus.out_tag); end
        total++; if (bus.out_exp !== 8'h9F) begin bad++; $display("FAIL mid_after_exp: got %h want 9f", bus.out_exp); end
    endtask

    initial begin
        test_reset();
        test_norm(2, 8'h05, 25'h0800000, 8'h84, 23'h000000, 1'b0);
        test_norm(1, 8'h05, 25'h1000002, 8'h85, 23'h000001, 1'b0);
        test_norm(0, 8'h05, 25'h0000001, 8'h6D, 23'h000000, 1'b0);
        test_norm(3, 8'h22, 25'h0000000, 8'h00, 23'h000000, 1'b1);
        test_norm(2, 8'h05, 25'h0012345, 8'h7D, 23'h11A280, 1'b0);
        test_norm(1, 8'h80, 25'h1000000, 8'h00, 23'h000000, 1'b0);
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
